// File: rtl/score_life_tracker.sv
// Game-rule bookkeeping: frame-gated, debounced score and life counts and
// the ball respawn hold-off sequence for the pinball playfield.
module score_life_tracker #(
  parameter int INIT_LIFE          = 3,
  parameter int SCORE_MAX          = 9,
  parameter int RESPAWN_FRAMES     = 60,
  parameter int HIT_HOLDOFF_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       startOfFrame,
  input  logic       targetHit,
  input  logic       ballLost,
  output logic [3:0] life,
  output logic [3:0] score,
  output logic       respawn,
  output logic       gameOver
);

  localparam logic [3:0] LIFE_INIT = 4'(INIT_LIFE);
  localparam logic [3:0] SCORE_TOP = 4'(SCORE_MAX);
  localparam logic [7:0] RESP_LOAD = 8'(RESPAWN_FRAMES);
  localparam logic [7:0] HOLD_LOAD = 8'(HIT_HOLDOFF_FRAMES);

  typedef enum logic [1:0] {IDLE, PLAY, RESPAWN, OVER} state_t;

  state_t     state, state_nx;
  logic [3:0] life_nx, score_nx;
  logic [7:0] hold, hold_nx;
  logic [7:0] resp_cnt, resp_nx;
  logic       hit_prev;
  logic       hit;

  // A hit counts only on a fresh rising edge once the holdoff has expired.
  assign hit = targetHit & ~hit_prev & (hold == 8'd0);

  always_comb begin
    state_nx = state;
    life_nx  = life;
    score_nx = score;
    hold_nx  = hold;
    resp_nx  = resp_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = PLAY;
          life_nx  = LIFE_INIT;
          score_nx = 4'd0;
          hold_nx  = 8'd0;
        end
      end
      PLAY: begin
        if (!start) begin
          state_nx = IDLE;
        end else begin
          if (hit) begin
            if (score < SCORE_TOP) score_nx = score + 4'd1;
            hold_nx = HOLD_LOAD;
          end else if (startOfFrame && hold != 8'd0) begin
            hold_nx = hold - 8'd1;
          end
          if (ballLost) begin
            if (life > 4'd1) begin
              life_nx  = life - 4'd1;
              resp_nx  = RESP_LOAD;
              state_nx = RESPAWN;
            end else begin
              life_nx  = 4'd0;
              state_nx = OVER;
            end
          end
        end
      end
      RESPAWN: begin
        if (!start) begin
          state_nx = IDLE;
        end else if (startOfFrame && resp_cnt != 8'd0) begin
          resp_nx = resp_cnt - 8'd1;
          if (resp_cnt == 8'd1) begin
            state_nx = PLAY;
            hold_nx  = 8'd0;
          end
        end
      end
      OVER: begin
        life_nx = 4'd0;
        if (!start) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      life     <= LIFE_INIT;
      score    <= 4'd0;
      hold     <= 8'd0;
      resp_cnt <= 8'd0;
      hit_prev <= 1'b0;
      respawn  <= 1'b0;
      gameOver <= 1'b0;
    end else begin
      state    <= state_nx;
      life     <= life_nx;
      score    <= score_nx;
      hold     <= hold_nx;
      resp_cnt <= resp_nx;
      hit_prev <= targetHit;
      // Flags follow the next state so they change on the same edge as the FSM.
      respawn  <= (state_nx == RESPAWN);
      gameOver <= (state_nx == OVER);
    end
  end

endmodule

// File: tb/tb_score_life_tracker.sv
// Bench for score_life_tracker: directed game scenarios then random play,
// all cycles compared against a rule-level game model.
module tb_score_life_tracker;

  logic       clk = 1'b0;
  logic       reset, start, startOfFrame, targetHit, ballLost;
  logic [3:0] life, score;
  logic       respawn, gameOver;

  int total = 0;
  int bad   = 0;
  int fc    = 0;

  // reference model state (mode: 0 idle, 1 play, 2 respawn, 3 over)
  int m_mode, m_life, m_score, m_hold, m_resp;
  bit m_prev;

  score_life_tracker dut (
    .clk(clk), .reset(reset), .start(start), .startOfFrame(startOfFrame),
    .targetHit(targetHit), .ballLost(ballLost),
    .life(life), .score(score), .respawn(respawn), .gameOver(gameOver)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_step();
    bit edge_seen;
    edge_seen = targetHit && !m_prev;
    m_prev    = targetHit;
    if (reset) begin
      m_mode = 0; m_life = 3; m_score = 0; m_hold = 0; m_resp = 0; m_prev = 0;
      return;
    end
    case (m_mode)
      0: if (start) begin m_mode = 1; m_life = 3; m_score = 0; m_hold = 0; end
      1: if (!start) m_mode = 0;
         else begin
           if (edge_seen && m_hold == 0) begin
             m_score = (m_score + 1 > 9) ? 9 : m_score + 1;
             m_hold  = 8;
           end else if (startOfFrame && m_hold > 0) m_hold--;
           if (ballLost) begin
             if (m_life > 1) begin m_life--; m_resp = 60; m_mode = 2; end
             else begin m_life = 0; m_mode = 3; end
           end
         end
      2: if (!start) m_mode = 0;
         else if (startOfFrame && m_resp > 0) begin
           m_resp--;
           if (m_resp == 0) begin m_mode = 1; m_hold = 0; end
         end
      default: begin m_life = 0; if (!start) m_mode = 0; end
    endcase
  endtask

  // One clock: frame pulse every 4th cycle, model advanced on the edge,
  // outputs compared 1 time unit after it.
  task automatic tick();
    startOfFrame = (fc == 3);
    fc = (fc + 1) % 4;
    @(posedge clk);
    model_step();
    #1;
    chk("life", 8'(life), 8'(m_life));
    chk("score", 8'(score), 8'(m_score));
    chk("respawn", 8'(respawn), 8'(m_mode == 2));
    chk("gameOver", 8'(gameOver), 8'(m_mode == 3));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // single clean hit followed by a quiet gap longer than the holdoff
  task automatic hit_and_gap();
    targetHit = 1'b1; ticks(2);
    targetHit = 1'b0; ticks(36);
  endtask

  task automatic lose_ball_and_wait();
    ballLost = 1'b1; tick();
    ballLost = 1'b0; ticks(62 * 4);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; startOfFrame = 1'b0; targetHit = 1'b0; ballLost = 1'b0;
    m_mode = 0; m_life = 3; m_score = 0; m_hold = 0; m_resp = 0; m_prev = 0;
    ticks(2);
    reset = 1'b0;
    ticks(100);
    chk("idle_life", 8'(life), 8'd3);
    chk("idle_score", 8'(score), 8'd0);

    // long collision counts once, re-arms after holdoff
    start = 1'b1; tick();
    targetHit = 1'b1; ticks(20);
    chk("debounce", 8'(score), 8'd1);
    targetHit = 1'b0; ticks(36);
    targetHit = 1'b1; ticks(2);
    chk("second_hit", 8'(score), 8'd2);
    targetHit = 1'b0; ticks(36);

    for (int i = 0; i < 12; i++) hit_and_gap();
    chk("saturate", 8'(score), 8'd9);

    // ball loss, hits ignored during respawn
    ballLost = 1'b1; tick();
    ballLost = 1'b0;
    chk("lost_life", 8'(life), 8'd2);
    chk("lost_resp", 8'(respawn), 8'd1);
    targetHit = 1'b1; ticks(3);
    targetHit = 1'b0; ticks(3);
    chk("resp_ignore", 8'(score), 8'd9);
    ticks(60 * 4);
    chk("resp_done", 8'(respawn), 8'd0);

    lose_ball_and_wait();
    ballLost = 1'b1; tick();
    ballLost = 1'b0;
    chk("over_life", 8'(life), 8'd0);
    chk("over_flag", 8'(gameOver), 8'd1);
    ticks(5);
    start = 1'b0; tick();
    chk("idle_hold", 8'(score), 8'd9);
    ticks(3);
    start = 1'b1; tick();
    chk("restart_life", 8'(life), 8'd3);
    chk("restart_score", 8'(score), 8'd0);

    // simultaneous hit edge and ball loss, then mid-game reset
    for (int i = 0; i < 4; i++) hit_and_gap();
    lose_ball_and_wait();
    targetHit = 1'b1; ballLost = 1'b1; tick();
    targetHit = 1'b0; ballLost = 1'b0;
    chk("both_score", 8'(score), 8'd5);
    chk("both_life", 8'(life), 8'd1);
    chk("both_resp", 8'(respawn), 8'd1);
    ticks(10);
    reset = 1'b1; tick();
    reset = 1'b0; start = 1'b0;
    chk("rst_life", 8'(life), 8'd3);
    chk("rst_score", 8'(score), 8'd0);
    chk("rst_resp", 8'(respawn), 8'd0);

    // random play
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 149) == 0) start = ~start;
      else if (!start && $urandom_range(0, 9) == 0) start = 1'b1;
      if ($urandom_range(0, 5) == 0) targetHit = ~targetHit;
      ballLost = ($urandom_range(0, 79) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
